arp_request: RTL and testbench

- ARP initiator; the requesting counterpart to the existing ARP reply path.
- On `start`, it streams a 28-byte ARP request payload (OPER=1) to the MAC encoder for broadcast, then waits for a matching reply from `arp_decode`.
- Retransmits on timeout and reports the resolved MAC or a failure.
- Sits beside `arp_encode` in the `clk` TX domain and shares the `mac_encode` payload handshake (`en` / `ovalid` / `dout`).

---
 rtl/arp_pkg.sv | 24 ++
 rtl/arp_retry_timer.sv | 23 ++
 rtl/arp_request.sv | 157 +++++++++++++++
 tb/tb_arp_request.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// arp_pkg: ARP constants, request FSM state type and the request payload byte selector.
package arp_pkg;
    localparam logic [15:0] ARP_HTYPE_ETH   = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY  = 16'h0002;
    localparam logic [15:0] ETHERTYPE_ARP   = 16'h0806;
    localparam logic [47:0] BCAST_MAC       = 48'hFFFF_FFFF_FFFF;
    localparam int          ARP_PAYLOAD_LEN = 28;

    typedef enum logic [1:0] {IDLE, REQ, SEND, WAIT} arp_state_e;

    // Byte idx of a request payload, fields packed MSB-first.
    function automatic logic [7:0] arp_req_byte(
        input logic [4:0]  idx,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [31:0] tpa
    );
        logic [8*ARP_PAYLOAD_LEN-1:0] p;
        p = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, 8'd6, 8'd4, ARP_OPER_REQ, sha, spa, 48'h0, tpa} << {idx, 3'b000};
        return p[8*ARP_PAYLOAD_LEN-1 -: 8];
    endfunction
endpackage

// File: rtl/arp_retry_timer.sv
// arp_retry_timer: reply-wait counter; expire flags the last cycle of the RETRY_CYCLES window.
module arp_retry_timer #(
    parameter int RETRY_CYCLES = 125000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = RETRY_CYCLES > 1 ? $clog2(RETRY_CYCLES) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expire = en && cnt_q == W'(RETRY_CYCLES - 1);
endmodule

// File: rtl/arp_request.sv
// arp_request: ARP initiator - broadcasts a request, waits for the matching reply, retries, reports.
// Define ARP_GRATUITOUS_EN to add the announce input (gratuitous ARP for IP_ADDR).
module arp_request
    import arp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR     = 48'hDEADBEEFCAFE,
    parameter logic [31:0] IP_ADDR      = 32'h69696969,
    parameter int          RETRY_CYCLES = 125000000,
    parameter int          MAX_TRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef ARP_GRATUITOUS_EN
    input  logic        announce,
`endif
    input  logic [31:0] target_ip,
    output logic        tx_req,
    output logic [47:0] mac_dest,
    output logic [15:0] ethertype,
    input  logic        en,
    output logic        ovalid,
    output logic [7:0]  dout,
    input  logic        rx_done,
    input  logic [15:0] rx_oper,
    input  logic [47:0] rx_sha,
    input  logic [31:0] rx_spa,
    output logic        busy,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic        fail
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    arp_state_e    state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] try_q, try_d;
    logic [31:0]   tgt_q, tgt_d;
    logic [47:0]   mac_q, mac_d;
    logic          got_q, got_d;
    logic          resolved_q, resolved_d;
    logic          fail_q, fail_d;
    logic          go, grat, last, match, tmr_clr, expire;

`ifdef ARP_GRATUITOUS_EN
    logic grat_q, grat_d;

    always_comb grat_d = state_q == IDLE ? !start && announce : grat_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) grat_q <= 1'b0;
        else      grat_q <= grat_d;
    end

    assign go   = start || announce;
    assign grat = grat_q;
`else
    assign go   = start;
    assign grat = 1'b0;
`endif

    // got_q remembers a reply that arrived while the frame was still going out.
    assign last  = idx_q == 5'(ARP_PAYLOAD_LEN - 1);
    assign match = rx_done && rx_oper == ARP_OPER_REPLY && rx_spa == tgt_q
                && !grat && !got_q && state_q != IDLE;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        try_d      = try_q;
        tgt_d      = tgt_q;
        got_d      = got_q;
        mac_d      = mac_q;
        resolved_d = 1'b0;
        fail_d     = 1'b0;
        tmr_clr    = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                tgt_d   = start ? target_ip : IP_ADDR;
                try_d   = TW'(1);
                idx_d   = '0;
                got_d   = 1'b0;
                state_d = REQ;
            end
            REQ, SEND: if (en) begin
                idx_d   = last ? '0 : idx_q + 1'b1;
                tmr_clr = last;
                state_d = !last ? SEND : (got_q || match || grat) ? IDLE : WAIT;
                if (last && grat) begin
                    resolved_d = 1'b1;
                    mac_d      = MAC_ADDR;
                end
            end
            WAIT: if (expire) begin
                if (try_q == TW'(MAX_TRIES)) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    try_d   = try_q + 1'b1;
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // A reply beats a simultaneous timeout.
        if (match) begin
            resolved_d = 1'b1;
            mac_d      = rx_sha;
            got_d      = 1'b1;
            if (state_q == WAIT) begin
                fail_d  = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            try_q      <= '0;
            tgt_q      <= '0;
            mac_q      <= '0;
            got_q      <= 1'b0;
            resolved_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            try_q      <= try_d;
            tgt_q      <= tgt_d;
            mac_q      <= mac_d;
            got_q      <= got_d;
            resolved_q <= resolved_d;
            fail_q     <= fail_d;
        end
    end

    arp_retry_timer #(.RETRY_CYCLES(RETRY_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (state_q == WAIT),
        .expire (expire)
    );

    assign busy         = state_q != IDLE;
    assign ovalid       = state_q == REQ || state_q == SEND;
    assign tx_req       = ovalid;
    assign dout         = ovalid ? arp_req_byte(idx_q, MAC_ADDR, IP_ADDR, tgt_q) : 8'h00;
    assign mac_dest     = BCAST_MAC;
    assign ethertype    = ETHERTYPE_ARP;
    assign resolved     = resolved_q;
    assign resolved_mac = mac_q;
    assign fail         = fail_q;
endmodule

// File: tb/tb_arp_request.sv
// tb_arp_request: directed scenarios with random targets/MACs/en patterns, checked against a
// byte-list model of the request frame and the reply/timeout rules.
module tb_arp_request;
    localparam int RC = 16;
    localparam int MT = 3;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, en = 1'b0, rx_done = 1'b0;
    logic [31:0] target_ip = '0, rx_spa = '0;
    logic [15:0] rx_oper = '0;
    logic [47:0] rx_sha = '0;
    logic        tx_req, ovalid, busy, resolved, fail;
    logic [47:0] mac_dest, resolved_mac;
    logic [15:0] ethertype;
    logic [7:0]  dout;

    int cyc, res_cnt, fail_cnt, checks, passed, fails;

    arp_request #(.RETRY_CYCLES(RC), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .start(start), .target_ip(target_ip), .tx_req(tx_req),
        .mac_dest(mac_dest), .ethertype(ethertype), .en(en), .ovalid(ovalid), .dout(dout),
        .rx_done(rx_done), .rx_oper(rx_oper), .rx_sha(rx_sha), .rx_spa(rx_spa), .busy(busy),
        .resolved(resolved), .resolved_mac(resolved_mac), .fail(fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (resolved === 1'b1) res_cnt <= res_cnt + 1;
        if (fail === 1'b1) fail_cnt <= fail_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input logic [31:0] tpa);
        logic [7:0] b[28];
        b = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
              8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h69, 8'h69, 8'h69, 8'h69,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              tpa[31:24], tpa[23:16], tpa[15:8], tpa[7:0]};
        return b[i];
    endfunction

    task automatic reply(input logic [15:0] oper, input logic [31:0] spa, input logic [47:0] sha);
        rx_done = 1'b1; rx_oper = oper; rx_spa = spa; rx_sha = sha;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic kick(input logic [31:0] tgt);
        target_ip = tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        target_ip = $urandom;
    endtask

    // mode 0: en held high, 1: en one cycle in three, 2: random en
    task automatic frame(input logic [31:0] tpa, input int mode, input int match_at, input int abort_at,
                         input logic [47:0] sha, output int st, output int acc);
        int k, n;
        bit hit;
        k = 0; n = 0; hit = 0; acc = 0;
        for (int i = 0; i < RC + 8 && ovalid !== 1'b1; i++) @(negedge clk);
        st = cyc;
        while (k < 28 && n < 400) begin
            chk("ovalid", ovalid, 1);
            chk("tx_req", tx_req, 1);
            chk($sformatf("byte%0d", k), dout, exp_byte(k, tpa));
            if (k == abort_at) begin
                en = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("abort_ovalid", ovalid, 0);
                chk("abort_tx_req", tx_req, 0);
                chk("abort_busy", busy, 0);
                @(negedge clk);
                rst = 1'b1;
                acc = cyc;
                return;
            end
            en = mode == 0 || (mode == 1 ? n % 3 == 2 : $urandom_range(0, 1) == 1);
            if (k == match_at && !hit) begin
                hit = 1;
                rx_done = 1'b1; rx_oper = 16'h0002; rx_spa = tpa; rx_sha = sha;
            end
            @(negedge clk);
            rx_done = 1'b0;
            if (en) k++;
            n++;
        end
        en = 1'b0;
        acc = cyc;
        chk("frame_len", k, 28);
        chk("frame_end_ovalid", ovalid, 0);
        chk("frame_end_tx_req", tx_req, 0);
    endtask

    initial begin
        int st, acc, acc0, exp_res;
        logic [31:0] tgt;
        logic [47:0] sha;
        exp_res = 0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tx_req", tx_req, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_resolved", resolved, 0);
        chk("rst_fail", fail, 0);
        chk("rst_resolved_mac", resolved_mac, 0);
        chk("mac_dest", mac_dest, 48'hFFFFFFFFFFFF);
        chk("ethertype", ethertype, 16'h0806);
        rst = 1'b1;
        @(negedge clk);

        // basic request, reply lands in WAIT
        tgt = 32'h0A000001;
        kick(tgt);
        frame(tgt, 0, -1, -1, '0, st, acc);
        repeat ($urandom_range(1, RC - 3)) @(negedge clk);
        chk("wait_busy", busy, 1);
        reply(16'h0002, tgt, 48'h001122334455);
        exp_res++;
        chk("wait_resolved", resolved, 1);
        chk("wait_mac", resolved_mac, 48'h001122334455);
        chk("wait_busy_after", busy, 0);
        @(negedge clk);
        chk("wait_resolved_pulse", resolved, 0);

        // three tries, filtered replies, then fail
        tgt = $urandom;
        kick(tgt);
        frame(tgt, 2, -1, -1, '0, st, acc);
        reply(16'h0002, tgt + 32'd1, 48'($urandom));
        reply(16'h0001, tgt, 48'($urandom));
        acc0 = acc;
        frame(tgt, 2, -1, -1, '0, st, acc);
        chk("retry_gap1", st - acc0, RC);
        acc0 = acc;
        frame(tgt, 2, -1, -1, '0, st, acc);
        chk("retry_gap2", st - acc0, RC);
        for (int i = 0; i < RC + 4 && busy === 1'b1; i++) @(negedge clk);
        chk("fail_time", cyc - acc, RC);
        chk("fail_pulse", fail, 1);
        chk("fail_ovalid", ovalid, 0);
        @(negedge clk);
        chk("fail_pulse_end", fail, 0);
        chk("fail_idle", busy, 0);

        // throttled en with the reply arriving mid-frame
        tgt = $urandom;
        sha = 48'({$urandom, $urandom});
        kick(tgt);
        frame(tgt, 1, $urandom_range(1, 20), -1, sha, st, acc);
        exp_res++;
        chk("send_match_idle", busy, 0);
        chk("send_match_mac", resolved_mac, sha);

        // start while busy is ignored; only the latched target matches
        tgt = $urandom;
        sha = 48'({$urandom, $urandom});
        kick(tgt);
        frame(tgt, 0, -1, -1, '0, st, acc);
        target_ip = tgt ^ 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ovalid", ovalid, 0);
        reply(16'h0002, tgt ^ 32'h1, 48'($urandom));
        chk("busy_start_ignored", resolved, 0);
        chk("busy_start_busy", busy, 1);
        reply(16'h0002, tgt, sha);
        exp_res++;
        chk("busy_start_resolved", resolved, 1);
        chk("busy_start_mac", resolved_mac, sha);

        // reply on the expiry cycle wins over retransmission
        tgt = $urandom;
        sha = 48'({$urandom, $urandom});
        kick(tgt);
        frame(tgt, 0, -1, -1, '0, st, acc);
        repeat (RC - 1) @(negedge clk);
        reply(16'h0002, tgt, sha);
        exp_res++;
        chk("expiry_resolved", resolved, 1);
        chk("expiry_fail", fail, 0);
        chk("expiry_busy", busy, 0);
        @(negedge clk);
        chk("expiry_no_retx", ovalid, 0);

        // async reset at byte 10, then a clean restart
        tgt = $urandom;
        kick(tgt);
        frame(tgt, 0, -1, 10, '0, st, acc);
        chk("abort_mac_cleared", resolved_mac, 0);
        tgt = $urandom;
        sha = 48'({$urandom, $urandom});
        kick(tgt);
        frame(tgt, 2, -1, -1, '0, st, acc);
        reply(16'h0002, tgt, sha);
        exp_res++;
        chk("restart_resolved", resolved, 1);
        chk("restart_mac", resolved_mac, sha);

        repeat (3) @(negedge clk);
        chk("resolved_count", res_cnt, exp_res);
        chk("fail_count", fail_cnt, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
